// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: streams a program into instruction memory, NOP-fills the tail,
// releases the core, and stops it on EBREAK or abort while counting run cycles.
module imem_boot_ctrl #(
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013,
    parameter logic [31:0] HALT_OP  = 32'h0010_0073
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       instr,
    output logic              core_reset,
    output logic [2:0]        state_o,
    output logic              halted,
    output logic              err,
    output logic [31:0]       run_cycles
);

    // Host stream handshake: a word transfers on a rising edge where s_valid and
    // s_ready are both high; s_ready is high exactly while in LOAD.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FILL   = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_L  = {1'b0, {ADDR_W{1'b1}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic [31:0]         run_cycles_q, run_cycles_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            ptr_q        <= '0;
            run_cycles_q <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            run_cycles_q <= run_cycles_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        run_cycles_d = run_cycles_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    if (prog_len == '0 || prog_len > DEPTH_L) begin
                        err_d = 1'b1;
                    end else begin
                        len_d        = prog_len;
                        ptr_d        = '0;
                        run_cycles_d = '0;
                        state_d      = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // An accepted word is always written, even when abort arrives with it.
                if (s_valid) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[ADDR_W-1:0];
                    wdata_d = s_data;
                    ptr_d   = ptr_q + 1'b1;
                    if (ptr_q == len_q - 1'b1) begin
                        state_d = (len_q < DEPTH_L) ? S_FILL : S_RUN;
                    end
                end
                if (abort) begin
                    state_d = S_HALTED;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d = S_HALTED;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[ADDR_W-1:0];
                    wdata_d = NOP_WORD;
                    ptr_d   = ptr_q + 1'b1;
                    if (ptr_q == LAST_L) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // The halting cycle itself is counted as a run cycle.
                if (run_cycles_q != '1) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
                if (abort || instr == HALT_OP) begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign s_ready    = (state_q == S_LOAD);
    assign core_reset = (state_q != S_RUN);
    assign halted     = (state_q == S_HALTED);
    assign state_o    = state_q;
    assign err        = err_q;
    assign run_cycles = run_cycles_q;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed + randomized bench for imem_boot_ctrl with a tiny memory/core model and
// a write scoreboard.
module tb_imem_boot_ctrl;

    localparam int          ADDR_W = 4;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] HALT   = 32'h0010_0073;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              abort;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [31:0]       instr;
    logic              core_reset;
    logic [2:0]        state_o;
    logic              halted;
    logic              err;
    logic [31:0]       run_cycles;

    imem_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .prog_len   (prog_len),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .instr      (instr),
        .core_reset (core_reset),
        .state_o    (state_o),
        .halted     (halted),
        .err        (err),
        .run_cycles (run_cycles)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory + minimal core model ----------------
    logic [31:0] mem_m [DEPTH];
    logic [3:0]  pc_m;
    logic [31:0] xreg [32];

    assign instr = mem_m[pc_m];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] <= 32'd0;
            for (int i = 0; i < 32; i++) xreg[i] <= 32'd0;
            pc_m <= 4'd0;
        end else begin
            if (imem_we) mem_m[imem_waddr] <= imem_wdata;
            if (core_reset) begin
                pc_m <= 4'd0;
            end else begin
                if (instr != HALT) pc_m <= pc_m + 4'd1;
                if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0 && instr[11:7] != 5'd0)
                    xreg[instr[11:7]] <= xreg[instr[19:15]] + {{20{instr[31]}}, instr[31:20]};
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];
    logic [31:0] prog [DEPTH];

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge and writes are scored.
    task automatic step();
        @(posedge clk);
        #1;
        if (imem_we) begin
            if (exp_q.size() == 0) chk("write_unexpected", 36'(imem_we), 36'd0);
            else chk("write", {imem_waddr, imem_wdata}, exp_q.pop_front());
        end
    endtask

    // ---------------- drivers ----------------
    task automatic start_load(input int len);
        start = 1'b1;
        prog_len = (ADDR_W+1)'(len);
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input int addr, input logic [31:0] w, input int gap);
        repeat (gap) begin
            s_valid = 1'b0;
            step();
        end
        chk("s_ready_load", 36'(s_ready), 36'd1);
        s_valid = 1'b1;
        s_data = w;
        exp_q.push_back({4'(addr), w});
        step();
        s_valid = 1'b0;
    endtask

    // Run length implied by the loaded image: up to and including the first EBREAK.
    function automatic int exp_run_cycles(input int len);
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = (i < len) ? prog[i] : NOP;
            if (w == HALT) return i + 1;
        end
        return 0;
    endfunction

    task automatic load_and_run(input int len, input int max_gap, input bool_gap_fixed);
        int n_fill;
        int g;
        int rc;
        rc = exp_run_cycles(len);
        start_load(len);
        chk("state_load", 36'(state_o), 36'd1);
        chk("run_cycles_cleared", 36'(run_cycles), 36'd0);
        for (int i = 0; i < len; i++)
            send_word(i, prog[i], bool_gap_fixed ? max_gap : int'($urandom_range(max_gap, 0)));
        for (int j = len; j < DEPTH; j++) exp_q.push_back({4'(j), NOP});
        n_fill = 0;
        g = 0;
        while (state_o == 3'd2 && g < 40) begin
            n_fill++;
            step();
            g++;
        end
        chk("fill_cycles", 36'(n_fill), 36'(DEPTH - len));
        chk("state_run", 36'(state_o), 36'd3);
        chk("core_reset_run", 36'(core_reset), 36'd0);
        g = 0;
        while (state_o == 3'd3 && g < 100) begin
            step();
            g++;
        end
        chk("state_halted", 36'(state_o), 36'd4);
        chk("halted_flag", 36'(halted), 36'd1);
        chk("core_reset_halted", 36'(core_reset), 36'd1);
        chk("run_cycles", 36'(run_cycles), 36'(rc));
        chk("writes_left", 36'(exp_q.size()), 36'd0);
    endtask

    task automatic random_prog(input int len, input int halt_at);
        for (int i = 0; i < DEPTH; i++) begin
            prog[i] = $urandom;
            if (prog[i] == HALT) prog[i] = prog[i] ^ 32'd1;
        end
        prog[halt_at] = HALT;
    endtask

    // ---------------- sequence ----------------
    initial begin
        int len;
        int g;
        rst = 1'b1;
        start = 1'b0;
        prog_len = '0;
        abort = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // reset values
        chk("rst_state", 36'(state_o), 36'd0);
        chk("rst_core_reset", 36'(core_reset), 36'd1);
        chk("rst_s_ready", 36'(s_ready), 36'd0);
        chk("rst_we", 36'(imem_we), 36'd0);
        chk("rst_waddr", 36'(imem_waddr), 36'd0);
        chk("rst_wdata", 36'(imem_wdata), 36'd0);
        chk("rst_halted", 36'(halted), 36'd0);
        chk("rst_err", 36'(err), 36'd0);
        chk("rst_run_cycles", 36'(run_cycles), 36'd0);

        // reset in the middle of LOAD after three words
        random_prog(8, 7);
        start_load(8);
        for (int i = 0; i < 3; i++) send_word(i, prog[i], 0);
        s_valid = 1'b1;
        s_data = prog[3];
        rst = 1'b1;
        step();
        s_valid = 1'b0;
        exp_q.delete();
        chk("midrst_state", 36'(state_o), 36'd0);
        chk("midrst_core_reset", 36'(core_reset), 36'd1);
        chk("midrst_we", 36'(imem_we), 36'd0);
        chk("midrst_s_ready", 36'(s_ready), 36'd0);
        rst = 1'b0;
        step();

        // illegal lengths
        for (int k = 0; k < 3; k++) begin
            len = (k == 0) ? 0 : (k == 1) ? 17 : int'($urandom_range(31, 18));
            start_load(len);
            chk("err_pulse", 36'(err), 36'd1);
            chk("err_state", 36'(state_o), 36'd0);
            step();
            chk("err_clear", 36'(err), 36'd0);
        end

        // len=3 with one-cycle gaps
        random_prog(3, 2);
        load_and_run(3, 1, 1'b1);

        // len=16 back-to-back
        random_prog(16, 15);
        load_and_run(16, 0, 1'b1);

        // addi x1,x0,5; addi x1,x1,1; ebreak
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0010_8093;
        prog[2] = HALT;
        load_and_run(3, 2, 1'b0);
        chk("x1_value", 36'(xreg[1]), 36'd6);

        // abort during FILL once address 7 has been written
        random_prog(4, 3);
        start_load(4);
        chk("restart_run_cycles", 36'(run_cycles), 36'd0);
        for (int i = 0; i < 4; i++) send_word(i, prog[i], int'($urandom_range(2, 0)));
        for (int j = 4; j <= 7; j++) exp_q.push_back({4'(j), NOP});
        g = 0;
        while (!(imem_we && imem_waddr == 4'd7) && g < 40) begin
            step();
            g++;
        end
        chk("abort_reached_7", 36'(imem_waddr), 36'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", 36'(state_o), 36'd4);
        chk("abort_no_write", 36'(imem_we), 36'd0);
        step();
        chk("abort_run_cycles", 36'(run_cycles), 36'd0);
        chk("abort_writes_left", 36'(exp_q.size()), 36'd0);
        random_prog(2, 1);
        load_and_run(2, 1, 1'b0);

        // abort together with the last word
        random_prog(2, 1);
        start_load(2);
        send_word(0, prog[0], 0);
        s_valid = 1'b1;
        s_data = prog[1];
        abort = 1'b1;
        exp_q.push_back({4'd1, prog[1]});
        step();
        s_valid = 1'b0;
        abort = 1'b0;
        chk("lastabort_state", 36'(state_o), 36'd4);
        step();
        chk("lastabort_no_fill", 36'(imem_we), 36'd0);
        chk("lastabort_writes_left", 36'(exp_q.size()), 36'd0);

        // randomized loads
        for (int k = 0; k < 6; k++) begin
            len = int'($urandom_range(16, 1));
            random_prog(len, int'($urandom_range(len - 1, 0)));
            load_and_run(len, 3, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
